// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin share of the single-port instruction RAM among cores (IMEM_ARB_FIXED_PRIO_EN selects fixed priority)
module imem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic [NUM_CORES-1:0]        core_valid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd,
  input  logic [DATA_W-1:0]           mem_dataout,
  output logic                        busy
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] grant_idx, winner;
  logic [LW-1:0] lat_cnt;
  logic any_req;
  assign any_req = |core_req;
`ifdef IMEM_ARB_FIXED_PRIO_EN
  // lowest-index requester wins
  always_comb begin
    winner = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (core_req[k]) winner = IW'(k);
  end
`else
  logic [IW-1:0] last_grant, cand;
  logic found;
  // first requester after the last served core, wrapping
  always_comb begin
    winner = '0;
    found = 1'b0;
    cand = last_grant;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = (cand == IW'(NUM_CORES - 1)) ? '0 : cand + 1'b1;
      if (core_req[cand] && !found) begin
        winner = cand;
        found = 1'b1;
      end
    end
  end
  // remember who was served last so it goes to the back of the line
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= IW'(NUM_CORES - 1);
    else if (state == READ && lat_cnt == '0) last_grant <= grant_idx;
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: DONE always returns to IDLE so the served core gets an edge to drop req
  always_comb
    state_nx = (state == IDLE) ? (any_req ? READ : IDLE) :
               (state == READ) ? ((lat_cnt == '0) ? DONE : READ) : IDLE;
  // outputs decoded from state
  always_comb busy = (state != IDLE);
  // grant capture, RAM drive, latency count and per-core data return
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      grant_idx  <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      lat_cnt    <= '0;
      core_rdata <= '0;
      core_valid <= '0;
    end else begin
      core_valid <= '0;
      if (state == IDLE && any_req) begin
        grant_idx <= winner;
        mem_addr  <= core_addr[winner*ADDR_W +: ADDR_W];
        mem_rd    <= 1'b1;
        lat_cnt   <= LW'(MEM_LAT - 1);
      end
      if (state == READ) begin
        if (lat_cnt == '0) begin
          core_rdata[grant_idx*DATA_W +: DATA_W] <= mem_dataout;
          core_valid[grant_idx] <= 1'b1;
          mem_rd <= 1'b0;
        end else lat_cnt <= lat_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table-driven and directed checks of imem_arbiter against a small RAM model
module tb_imem_arbiter;
  logic clk, reset;
  logic [3:0] core_req, core_valid, core_req3, core_valid3;
  logic [63:0] core_addr, core_rdata, core_addr3, core_rdata3;
  logic [15:0] mem_addr, mem_dataout, mem_addr3, mem_dataout3;
  logic mem_rd, busy, mem_rd3, busy3;
  int checks = 0, failures = 0;

  imem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_addr(core_addr),
    .core_rdata(core_rdata), .core_valid(core_valid), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_dataout(mem_dataout), .busy(busy));

  imem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .core_req(core_req3), .core_addr(core_addr3),
    .core_rdata(core_rdata3), .core_valid(core_valid3), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .mem_dataout(mem_dataout3), .busy(busy3));

  function automatic logic [15:0] ram(input logic [15:0] a);
    case (a)
      16'd2:   return 16'd18;
      16'd4:   return 16'd112;
      16'd6:   return 16'd144;
      16'd8:   return 16'd160;
      16'd10:  return 16'd194;
      16'd12:  return 16'd128;
      default: return 16'hBEEF;
    endcase
  endfunction

  assign mem_dataout  = mem_rd  ? ram(mem_addr)  : 16'hDEAD;
  assign mem_dataout3 = mem_rd3 ? ram(mem_addr3) : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] addr;
    logic        rd;
    logic [15:0] maddr;
    logic        bsy;
    logic [3:0]  valid;
    logic [63:0] rdata;
  } vec_t;

  localparam logic [63:0] A0 = {16'd0, 16'd0, 16'd0, 16'd2};
  localparam logic [63:0] A1 = {16'd10, 16'd8, 16'd6, 16'd4};
  localparam logic [63:0] A2 = {16'd10, 16'd12, 16'd6, 16'd4};
  localparam logic [63:0] R1 = {16'd0, 16'd0, 16'd0, 16'd18};
  localparam logic [63:0] R2 = {16'd0, 16'd0, 16'd0, 16'd112};
  localparam logic [63:0] R3 = {16'd0, 16'd0, 16'd144, 16'd112};
  localparam logic [63:0] R4 = {16'd0, 16'd160, 16'd144, 16'd112};
  localparam logic [63:0] R5 = {16'd194, 16'd160, 16'd144, 16'd112};
  localparam logic [63:0] R6 = {16'd194, 16'd128, 16'd144, 16'd112};

  vec_t tbl [20];
  logic [3:0] seq [4];
  logic [3:0] exp_seq [4];
  logic [3:0] got;

  initial begin
    tbl = '{
      '{1'b1, 4'b0000, A0, 1'b0, 16'd0,  1'b0, 4'b0000, 64'd0},
      '{1'b0, 4'b0001, A0, 1'b1, 16'd2,  1'b1, 4'b0000, 64'd0},
      '{1'b0, 4'b0001, A0, 1'b0, 16'd2,  1'b1, 4'b0001, R1},
      '{1'b0, 4'b0000, A0, 1'b0, 16'd2,  1'b0, 4'b0000, R1},
      '{1'b1, 4'b0000, A1, 1'b0, 16'd0,  1'b0, 4'b0000, 64'd0},
      '{1'b0, 4'b1111, A1, 1'b1, 16'd4,  1'b1, 4'b0000, 64'd0},
      '{1'b0, 4'b1111, A1, 1'b0, 16'd4,  1'b1, 4'b0001, R2},
      '{1'b0, 4'b1110, A1, 1'b0, 16'd4,  1'b0, 4'b0000, R2},
      '{1'b0, 4'b1110, A1, 1'b1, 16'd6,  1'b1, 4'b0000, R2},
      '{1'b0, 4'b1110, A1, 1'b0, 16'd6,  1'b1, 4'b0010, R3},
      '{1'b0, 4'b1100, A1, 1'b0, 16'd6,  1'b0, 4'b0000, R3},
      '{1'b0, 4'b1100, A1, 1'b1, 16'd8,  1'b1, 4'b0000, R3},
      '{1'b0, 4'b1100, A1, 1'b0, 16'd8,  1'b1, 4'b0100, R4},
      '{1'b0, 4'b1100, A2, 1'b0, 16'd8,  1'b0, 4'b0000, R4},
      '{1'b0, 4'b1100, A2, 1'b1, 16'd10, 1'b1, 4'b0000, R4},
      '{1'b0, 4'b1100, A2, 1'b0, 16'd10, 1'b1, 4'b1000, R5},
      '{1'b0, 4'b0100, A2, 1'b0, 16'd10, 1'b0, 4'b0000, R5},
      '{1'b0, 4'b0100, A2, 1'b1, 16'd12, 1'b1, 4'b0000, R5},
      '{1'b0, 4'b0100, A2, 1'b0, 16'd12, 1'b1, 4'b0100, R6},
      '{1'b0, 4'b0000, A2, 1'b0, 16'd12, 1'b0, 4'b0000, R6}
    };
`ifdef IMEM_ARB_FIXED_PRIO_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
    reset = 1'b1;
    core_req = '0;
    core_addr = '0;
    core_req3 = '0;
    core_addr3 = '0;
    tick();
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst;
      core_req = tbl[i].req;
      core_addr = tbl[i].addr;
      tick();
      chk($sformatf("v%0d mem_rd", i), 64'(mem_rd), 64'(tbl[i].rd));
      chk($sformatf("v%0d mem_addr", i), 64'(mem_addr), 64'(tbl[i].maddr));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
      chk($sformatf("v%0d core_valid", i), 64'(core_valid), 64'(tbl[i].valid));
      chk($sformatf("v%0d core_rdata", i), core_rdata, tbl[i].rdata);
    end

    // reset while core 1's access is in READ
    reset = 1'b1;
    core_req = '0;
    tick();
    reset = 1'b0;
    core_addr = {16'd0, 16'd0, 16'd4, 16'd0};
    core_req = 4'b0010;
    tick();
    chk("abort pre mem_rd", 64'(mem_rd), 64'd1);
    chk("abort pre mem_addr", 64'(mem_addr), 64'd4);
    #2 reset = 1'b1;
    #1;
    chk("abort async mem_rd", 64'(mem_rd), 64'd0);
    chk("abort async mem_addr", 64'(mem_addr), 64'd0);
    chk("abort async busy", 64'(busy), 64'd0);
    chk("abort async rdata", core_rdata, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort held valid", 64'(core_valid), 64'd0);
    end
    reset = 1'b0;
    tick();
    chk("abort retry mem_rd", 64'(mem_rd), 64'd1);
    chk("abort retry valid early", 64'(core_valid), 64'd0);
    tick();
    chk("abort retry valid", 64'(core_valid), 64'b0010);
    chk("abort retry rdata", core_rdata, {16'd0, 16'd0, 16'd112, 16'd0});
    core_req = '0;
    tick();

    // cores 0 and 3 requesting continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core_addr = {16'd10, 16'd0, 16'd0, 16'd4};
    core_req = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      got = '0;
      for (int c = 0; c < 10 && got == '0; c++) begin
        tick();
        got = core_valid;
      end
      seq[n] = got;
      chk($sformatf("pair grant %0d", n), 64'(seq[n]), 64'(exp_seq[n]));
    end
    core_req = '0;
    tick();
    tick();

    // MEM_LAT=3 instance, core 1 address 6
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core_addr3 = {16'd0, 16'd0, 16'd6, 16'd0};
    core_req3 = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("lat3 mem_rd c%0d", c), 64'(mem_rd3), 64'd1);
      chk($sformatf("lat3 valid c%0d", c), 64'(core_valid3), 64'd0);
      chk($sformatf("lat3 mem_addr c%0d", c), 64'(mem_addr3), 64'd6);
    end
    tick();
    chk("lat3 mem_rd end", 64'(mem_rd3), 64'd0);
    chk("lat3 valid", 64'(core_valid3), 64'b0010);
    chk("lat3 rdata", core_rdata3, {16'd0, 16'd0, 16'd144, 16'd0});
    chk("lat3 busy", 64'(busy3), 64'd1);
    core_req3 = '0;
    tick();
    chk("lat3 idle busy", 64'(busy3), 64'd0);
    chk("lat3 valid cleared", 64'(core_valid3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
